// File: rtl/cache_fill_ctrl.sv
// Cache-miss block fill controller: fetches a whole block from memory under a
// ready/valid handshake, bypasses the missed word early and writes the tag last.
module cache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8,
    parameter bit CWF    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_detected,
    input  logic [ADDR_W-1:0]        miss_address,
    input  logic                     mem_ready,
    input  logic                     mem_data_valid,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     fsm_busy,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     write_data_array,
    output logic [$clog2(WORDS)-1:0] write_word,
    output logic [DATA_W-1:0]        write_data,
    output logic                     write_tag_array,
    output logic [ADDR_W-1:0]        tag_addr,
    output logic                     crit_valid,
    output logic [DATA_W-1:0]        crit_data
);

    localparam int BPW   = DATA_W / 8;
    localparam int OFF_W = $clog2(WORDS);
    localparam int BOFF  = $clog2(BPW);
    localparam int CNT_W = OFF_W + 1;
    localparam int BLK_W = OFF_W + BOFF;
    localparam logic [ADDR_W-1:0] BLK_MASK = {{(ADDR_W-BLK_W){1'b1}}, {BLK_W{1'b0}}};
    localparam logic [CNT_W-1:0]  WORDS_C  = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base;
    logic [OFF_W-1:0]  crit;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  ret_cnt;
    logic [DATA_W-1:0] crit_q;
    logic [OFF_W-1:0]  issue_idx;
    logic [OFF_W-1:0]  ret_idx;
    logic              issue_fire;
    logic              ret_fire;

    // Word order: wrap from the missed word, or plain linear from word 0.
    always_comb begin
        issue_idx = issue_cnt[OFF_W-1:0];
        ret_idx   = ret_cnt[OFF_W-1:0];
        if (CWF) begin
            issue_idx = crit + issue_cnt[OFF_W-1:0];
            ret_idx   = crit + ret_cnt[OFF_W-1:0];
        end
    end

    assign issue_fire = (state == FILL) && (issue_cnt < WORDS_C) && mem_ready;
    assign ret_fire   = (state == FILL) && mem_data_valid && (ret_cnt < issue_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (miss_detected) state_next = FILL;
            FILL:    if (ret_fire && (ret_cnt == LAST_C)) state_next = TAG;
            TAG:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Returns only count against requests already issued, so stray valids are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            base      <= '0;
            crit      <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            crit_q    <= '0;
        end else begin
            if ((state == IDLE) && miss_detected) begin
                base      <= miss_address & BLK_MASK;
                crit      <= miss_address[BLK_W-1:BOFF];
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end
            if (issue_fire) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (ret_fire) begin
                ret_cnt <= ret_cnt + CNT_W'(1);
                if (ret_idx == crit) begin
                    crit_q <= mem_data;
                end
            end
        end
    end

    always_comb begin
        fsm_busy         = (state != IDLE) || miss_detected;
        mem_req          = 1'b0;
        mem_addr         = '0;
        write_data_array = 1'b0;
        write_word       = '0;
        write_data       = '0;
        write_tag_array  = 1'b0;
        tag_addr         = base;
        crit_valid       = 1'b0;
        crit_data        = crit_q;
        case (state)
            FILL: begin
                mem_req = issue_cnt < WORDS_C;
                if (mem_req) begin
                    mem_addr = base + (ADDR_W'(issue_idx) << BOFF);
                end
                if (ret_fire) begin
                    write_data_array = 1'b1;
                    write_word       = ret_idx;
                    write_data       = mem_data;
                    if (ret_idx == crit) begin
                        crit_valid = 1'b1;
                        crit_data  = mem_data;
                    end
                end
            end
            TAG:     write_tag_array = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: a 4-cycle-latency memory model feeds three
// instances (wrap order, linear order, 4-word/32-bit) one at a time.
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        mem_ready;
    logic        mem_data_valid;
    logic [31:0] mem_data;
    int          sel;
    int          ready_mode;
    int          cyc;
    int          vectors;
    int          miscompares;

    always #5 clk = ~clk;

    logic        a_busy, a_req, a_wr, a_tag, a_cv;
    logic [15:0] a_addr, a_wdata, a_tag_addr, a_cd;
    logic [2:0]  a_word;
    logic        b_busy, b_req, b_wr, b_tag, b_cv;
    logic [15:0] b_addr, b_wdata, b_tag_addr, b_cd;
    logic [2:0]  b_word;
    logic        c_busy, c_req, c_wr, c_tag, c_cv;
    logic [15:0] c_addr, c_tag_addr;
    logic [31:0] c_wdata, c_cd;
    logic [1:0]  c_word;
    logic        md_a, md_b, md_c;

    assign md_a = miss_detected && (sel == 0);
    assign md_b = miss_detected && (sel == 1);
    assign md_c = miss_detected && (sel == 2);

    cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .CWF(1'b1)) dut_a (
        .clk(clk), .rst(rst), .miss_detected(md_a), .miss_address(miss_address),
        .mem_ready(mem_ready), .mem_data_valid(mem_data_valid), .mem_data(mem_data[15:0]),
        .fsm_busy(a_busy), .mem_req(a_req), .mem_addr(a_addr),
        .write_data_array(a_wr), .write_word(a_word), .write_data(a_wdata),
        .write_tag_array(a_tag), .tag_addr(a_tag_addr), .crit_valid(a_cv), .crit_data(a_cd)
    );

    cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .CWF(1'b0)) dut_b (
        .clk(clk), .rst(rst), .miss_detected(md_b), .miss_address(miss_address),
        .mem_ready(mem_ready), .mem_data_valid(mem_data_valid), .mem_data(mem_data[15:0]),
        .fsm_busy(b_busy), .mem_req(b_req), .mem_addr(b_addr),
        .write_data_array(b_wr), .write_word(b_word), .write_data(b_wdata),
        .write_tag_array(b_tag), .tag_addr(b_tag_addr), .crit_valid(b_cv), .crit_data(b_cd)
    );

    cache_fill_ctrl #(.ADDR_W(16), .DATA_W(32), .WORDS(4), .CWF(1'b1)) dut_c (
        .clk(clk), .rst(rst), .miss_detected(md_c), .miss_address(miss_address),
        .mem_ready(mem_ready), .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .fsm_busy(c_busy), .mem_req(c_req), .mem_addr(c_addr),
        .write_data_array(c_wr), .write_word(c_word), .write_data(c_wdata),
        .write_tag_array(c_tag), .tag_addr(c_tag_addr), .crit_valid(c_cv), .crit_data(c_cd)
    );

    logic        o_busy, o_req, o_wr, o_tag, o_cv;
    logic [15:0] o_addr, o_tag_addr;
    logic [31:0] o_word, o_wdata, o_cd;

    // The memory model and checks always look at whichever instance is under test.
    always_comb begin
        o_busy = a_busy; o_req = a_req; o_addr = a_addr; o_wr = a_wr;
        o_word = 32'(a_word); o_wdata = 32'(a_wdata); o_tag = a_tag;
        o_tag_addr = a_tag_addr; o_cv = a_cv; o_cd = 32'(a_cd);
        if (sel == 1) begin
            o_busy = b_busy; o_req = b_req; o_addr = b_addr; o_wr = b_wr;
            o_word = 32'(b_word); o_wdata = 32'(b_wdata); o_tag = b_tag;
            o_tag_addr = b_tag_addr; o_cv = b_cv; o_cd = 32'(b_cd);
        end else if (sel == 2) begin
            o_busy = c_busy; o_req = c_req; o_addr = c_addr; o_wr = c_wr;
            o_word = 32'(c_word); o_wdata = c_wdata; o_tag = c_tag;
            o_tag_addr = c_tag_addr; o_cv = c_cv; o_cd = c_cd;
        end
    end

    logic [15:0] pend_addr[$];
    int          pend_due[$];
    logic [15:0] req_log[$];
    int          req_cyc[$];
    logic [31:0] word_log[$];
    logic [31:0] data_log[$];
    int          exp_addr[$];
    int          exp_word[$];
    logic [15:0] exp_base;
    int          exp_bpw;
    int          crit_cnt, crit_at, tag_cnt, tag_cyc, last_ret_cyc, fall_cyc, hold_err;
    logic [31:0] crit_val;
    logic [15:0] tag_addr_seen, prev_addr;
    logic        stalled;

    function automatic logic [31:0] model_data(input logic [15:0] a);
        return {~a, a ^ 16'hA500};
    endfunction

    function automatic logic [31:0] dmask();
        return (sel == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_logs();
        req_log.delete(); req_cyc.delete(); word_log.delete(); data_log.delete();
        crit_cnt = 0; crit_at = -1; tag_cnt = 0; tag_cyc = -1; last_ret_cyc = -1;
        fall_cyc = -1; hold_err = 0; crit_val = '0; tag_addr_seen = '0;
        stalled = 1'b0; prev_addr = '0;
    endtask

    // One clock: observe mid-cycle, then set up the memory inputs for the next cycle.
    task automatic apply_stimulus();
        @(negedge clk);
        if (o_req && mem_ready) begin
            pend_addr.push_back(o_addr);
            pend_due.push_back(cyc + 4);
        end
        if (!rst) begin
            if (stalled && (!o_req || (o_addr != prev_addr))) hold_err++;
            stalled   = o_req && !mem_ready;
            prev_addr = o_addr;
            if (o_req && mem_ready) begin
                req_log.push_back(o_addr);
                req_cyc.push_back(cyc);
            end
            if (o_wr) begin
                word_log.push_back(o_word);
                data_log.push_back(o_wdata);
                last_ret_cyc = cyc;
            end
            if (o_cv) begin
                crit_cnt++;
                crit_at  = word_log.size() - 1;
                crit_val = o_cd;
            end
            if (o_tag) begin
                tag_cnt++;
                tag_cyc       = cyc;
                tag_addr_seen = o_tag_addr;
            end
            if (!o_busy && (cyc > 0) && (fall_cyc < 0)) fall_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        mem_data_valid = 1'b0;
        mem_data       = 32'hDEAD_BEEF;
        if ((pend_due.size() > 0) && (pend_due[0] <= cyc)) begin
            mem_data_valid = 1'b1;
            mem_data       = model_data(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        mem_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 1);
    endtask

    task automatic start_miss(input logic [15:0] addr);
        miss_address  = addr;
        miss_detected = 1'b1;
        cyc           = 0;
        #1;
        check_output("busy_in_miss_cycle", 32'(o_busy), 32'd1);
        apply_stimulus();
        miss_detected = 1'b0;
    endtask

    task automatic run_fill(input string tag);
        int n = 0;
        while ((fall_cyc < 0) && (n < 200)) begin
            apply_stimulus();
            n++;
        end
        check_output({tag, "_completes"}, 32'(fall_cyc >= 0), 32'd1);
    endtask

    task automatic check_fill(input string tag);
        logic [15:0] a;
        check_output({tag, "_req_count"}, 32'(req_log.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < req_log.size())
                check_output($sformatf("%s_req%0d", tag, i), 32'(req_log[i]), 32'(exp_addr[i]));
        end
        check_output({tag, "_write_count"}, 32'(word_log.size()), 32'(exp_word.size()));
        for (int i = 0; i < exp_word.size(); i++) begin
            if (i < word_log.size()) begin
                a = exp_base + 16'(exp_word[i] * exp_bpw);
                check_output($sformatf("%s_word%0d", tag, i), word_log[i], 32'(exp_word[i]));
                check_output($sformatf("%s_data%0d", tag, i), data_log[i], model_data(a) & dmask());
            end
        end
        check_output({tag, "_tag_count"}, 32'(tag_cnt), 32'd1);
        check_output({tag, "_tag_addr"}, 32'(tag_addr_seen), 32'(exp_base));
        check_output({tag, "_tag_after_last"}, 32'(tag_cyc), 32'(last_ret_cyc + 1));
        check_output({tag, "_busy_fall"}, 32'(fall_cyc), 32'(last_ret_cyc + 2));
        check_output({tag, "_crit_count"}, 32'(crit_cnt), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy"}, 32'(o_busy), 32'd0);
        check_output({tag, "_req"}, 32'(o_req), 32'd0);
        check_output({tag, "_addr"}, 32'(o_addr), 32'd0);
        check_output({tag, "_wr"}, 32'(o_wr), 32'd0);
        check_output({tag, "_word"}, o_word, 32'd0);
        check_output({tag, "_wdata"}, o_wdata, 32'd0);
        check_output({tag, "_tag"}, 32'(o_tag), 32'd0);
        check_output({tag, "_tag_addr"}, 32'(o_tag_addr), 32'd0);
        check_output({tag, "_cv"}, 32'(o_cv), 32'd0);
        check_output({tag, "_cd"}, o_cd, 32'd0);
    endtask

    initial begin
        int n;
        vectors = 0; miscompares = 0; sel = 0; ready_mode = 0; cyc = 0;
        rst = 1'b1; miss_detected = 1'b0; miss_address = '0;
        mem_ready = 1'b1; mem_data_valid = 1'b0; mem_data = '0;
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset_a");
        sel = 2;
        #1;
        check_all_zero("reset_c");

        // Wrap order, memory always ready.
        sel = 0; clear_logs();
        exp_base = 16'h1230; exp_bpw = 2;
        exp_addr = '{'h1234, 'h1236, 'h1238, 'h123A, 'h123C, 'h123E, 'h1230, 'h1232};
        exp_word = '{2, 3, 4, 5, 6, 7, 0, 1};
        start_miss(16'h1234);
        run_fill("cwf");
        check_fill("cwf");
        check_output("cwf_first_req_cyc", 32'(req_cyc.size() > 0 ? req_cyc[0] : -1), 32'd1);
        check_output("cwf_last_req_cyc", 32'(req_cyc.size() > 7 ? req_cyc[7] : -1), 32'd8);
        check_output("cwf_last_ret_cyc", 32'(last_ret_cyc), 32'd12);
        check_output("cwf_crit_first", 32'(crit_at), 32'd0);
        check_output("cwf_crit_val", crit_val, 32'h0000_B734);
        check_output("cwf_crit_hold", o_cd, 32'h0000_B734);

        // Linear order.
        sel = 1; clear_logs();
        exp_addr = '{'h1230, 'h1232, 'h1234, 'h1236, 'h1238, 'h123A, 'h123C, 'h123E};
        exp_word = '{0, 1, 2, 3, 4, 5, 6, 7};
        start_miss(16'h1234);
        run_fill("lin");
        check_fill("lin");
        check_output("lin_crit_third", 32'(crit_at), 32'd2);
        check_output("lin_crit_val", crit_val, 32'h0000_B734);

        // Memory ready pattern 1,0,0 repeating.
        sel = 0; clear_logs(); ready_mode = 1;
        exp_addr = '{'h1234, 'h1236, 'h1238, 'h123A, 'h123C, 'h123E, 'h1230, 'h1232};
        exp_word = '{2, 3, 4, 5, 6, 7, 0, 1};
        start_miss(16'h1234);
        run_fill("stall");
        check_fill("stall");
        check_output("stall_hold", 32'(hold_err), 32'd0);
        check_output("stall_last_req_cyc", 32'(req_cyc.size() > 7 ? req_cyc[7] : -1), 32'd22);
        ready_mode = 0;

        // Stray returns in IDLE and before any request, second miss during FILL.
        clear_logs();
        mem_data_valid = 1'b1; mem_data = 32'h0000_5A5A;
        apply_stimulus();
        mem_data_valid = 1'b1;
        apply_stimulus();
        check_output("spur_idle_writes", 32'(word_log.size()), 32'd0);
        check_output("spur_idle_busy", 32'(o_busy), 32'd0);
        clear_logs();
        start_miss(16'h1234);
        mem_data_valid = 1'b1; mem_data = 32'h0000_5A5A;
        apply_stimulus();
        apply_stimulus();
        miss_detected = 1'b1; miss_address = 16'h5678;
        apply_stimulus();
        miss_detected = 1'b0;
        run_fill("spur");
        check_fill("spur");

        // Reset after three returns, then a fresh miss in another block.
        clear_logs();
        start_miss(16'h1234);
        n = 0;
        while ((word_log.size() < 3) && (n < 40)) begin
            apply_stimulus();
            n++;
        end
        check_output("rst_three_returns", 32'(word_log.size()), 32'd3);
        rst = 1'b1;
        apply_stimulus();
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        n = 0;
        while ((pend_due.size() > 0) && (n < 20)) begin
            apply_stimulus();
            n++;
        end
        check_output("rst_late_writes", 32'(word_log.size()), 32'd3);
        check_output("rst_req_count", 32'(req_log.size()), 32'd7);
        check_output("rst_no_tag", 32'(tag_cnt), 32'd0);
        clear_logs();
        exp_base = 16'h00F0;
        exp_addr = '{'h00FE, 'h00F0, 'h00F2, 'h00F4, 'h00F6, 'h00F8, 'h00FA, 'h00FC};
        exp_word = '{7, 0, 1, 2, 3, 4, 5, 6};
        start_miss(16'h00FE);
        run_fill("refill");
        check_fill("refill");
        check_output("refill_crit_val", crit_val, 32'h0000_A5FE);

        // Four 32-bit words per block.
        sel = 2; clear_logs();
        exp_base = 16'h0000; exp_bpw = 4;
        exp_addr = '{'h0008, 'h000C, 'h0000, 'h0004};
        exp_word = '{2, 3, 0, 1};
        start_miss(16'h0008);
        run_fill("w4");
        check_fill("w4");
        check_output("w4_last_ret_cyc", 32'(last_ret_cyc), 32'd8);
        check_output("w4_crit_first", 32'(crit_at), 32'd0);
        check_output("w4_crit_val", crit_val, 32'hFFF7_A508);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
